// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: generates 8086 (two) or MCS-80 (three) INTA pulses and captures the vector.
// Optional opcode checking of the MCS-80 first byte is compiled in with `define INTA_OPCODE_CHECK_EN.
module inta_sequencer #(
    parameter int unsigned INTA_LOW_CYCLES = 2,
    parameter int unsigned INTA_GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        interrupt_request,
    input  logic        interrupt_enable,
    input  logic        u8086_or_mcs80_config,
    input  logic [7:0]  data_bus_in,
    input  logic        vector_ready,
    output logic        interrupt_acknowledge_n,
    output logic        busy,
    output logic        vector_valid,
    output logic [15:0] vector_data,
    output logic        opcode_error
);

    localparam logic [3:0] LOW_LAST = 4'(INTA_LOW_CYCLES - 1);
    localparam logic [3:0] GAP_LAST = 4'(INTA_GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE_LOW,
        PULSE_GAP,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;      // 1 = 8086, latched at sequence start
    logic [7:0]  low_q, low_d;        // MCS-80 low byte staged until the final capture
    logic [15:0] data_q, data_d;
    logic        last_pulse;

`ifdef INTA_OPCODE_CHECK_EN
    logic        bad_q, bad_d;
    logic        err_q, err_d;
`endif

    assign last_pulse = mode_q ? (idx_q == 2'd1) : (idx_q == 2'd2);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        low_d   = low_q;
        data_d  = data_q;
`ifdef INTA_OPCODE_CHECK_EN
        bad_d   = bad_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (interrupt_request && interrupt_enable) begin
                    state_d = PULSE_LOW;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    mode_d  = u8086_or_mcs80_config;
`ifdef INTA_OPCODE_CHECK_EN
                    bad_d   = 1'b0;
`endif
                end
            end
            PULSE_LOW: begin
                if (cnt_q == LOW_LAST) begin
                    cnt_d = 4'd0;
                    if (last_pulse) begin
                        state_d = HOLD;
                        data_d  = mode_q ? {8'h00, data_bus_in} : {data_bus_in, low_q};
`ifdef INTA_OPCODE_CHECK_EN
                        err_d   = bad_q;
`endif
                    end else begin
                        state_d = PULSE_GAP;
                        if (!mode_q && idx_q == 2'd1)
                            low_d = data_bus_in;
`ifdef INTA_OPCODE_CHECK_EN
                        if (!mode_q && idx_q == 2'd0)
                            bad_d = (data_bus_in != 8'hCD);
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PULSE_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 4'd0;
                    idx_d   = idx_q + 2'd1;
                    state_d = PULSE_LOW;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                // Returning to IDLE guarantees one idle edge before the next start.
                if (vector_ready) begin
                    state_d = IDLE;
`ifdef INTA_OPCODE_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            mode_q  <= 1'b0;
            low_q   <= 8'h00;
            data_q  <= 16'h0000;
`ifdef INTA_OPCODE_CHECK_EN
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            low_q   <= low_d;
            data_q  <= data_d;
`ifdef INTA_OPCODE_CHECK_EN
            bad_q   <= bad_d;
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decode straight from state so reset releases INTA without waiting for an edge.
    assign interrupt_acknowledge_n = (state_q != PULSE_LOW);
    assign busy                    = (state_q != IDLE);
    assign vector_valid            = (state_q == HOLD);
    assign vector_data             = data_q;
`ifdef INTA_OPCODE_CHECK_EN
    assign opcode_error            = err_q;
`else
    assign opcode_error            = 1'b0;
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer with default pulse timing (2 low / 2 gap).
module tb_inta_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        interrupt_request;
    logic        interrupt_enable;
    logic        u8086_or_mcs80_config;
    logic [7:0]  data_bus_in;
    logic        vector_ready;
    logic        interrupt_acknowledge_n;
    logic        busy;
    logic        vector_valid;
    logic [15:0] vector_data;
    logic        opcode_error;

    int errors = 0;
    int checks = 0;

`ifdef INTA_OPCODE_CHECK_EN
    localparam logic EXP_BAD_OPC = 1'b1;
`else
    localparam logic EXP_BAD_OPC = 1'b0;
`endif

    inta_sequencer dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .interrupt_request      (interrupt_request),
        .interrupt_enable       (interrupt_enable),
        .u8086_or_mcs80_config  (u8086_or_mcs80_config),
        .data_bus_in            (data_bus_in),
        .vector_ready           (vector_ready),
        .interrupt_acknowledge_n(interrupt_acknowledge_n),
        .busy                   (busy),
        .vector_valid           (vector_valid),
        .vector_data            (vector_data),
        .opcode_error           (opcode_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        interrupt_request = 1'b0;
        interrupt_enable = 1'b1;
        u8086_or_mcs80_config = 1'b1;
        data_bus_in = 8'h00;
        vector_ready = 1'b0;
        #12;
        chk("rst_inta", 16'(interrupt_acknowledge_n), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_valid", 16'(vector_valid), 16'd0);
        chk("rst_data", vector_data, 16'h0000);
        chk("rst_err", 16'(opcode_error), 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("idle_inta", 16'(interrupt_acknowledge_n), 16'd1);

        // 8086: pulse-1 byte discarded, pulse-2 byte becomes the type
        interrupt_request = 1'b1;
        data_bus_in = 8'hAA;
        tick();  // edge 0
        chk("a_e0_inta", 16'(interrupt_acknowledge_n), 16'd0);
        chk("a_e0_busy", 16'(busy), 16'd1);
        interrupt_request = 1'b0;
        tick();
        chk("a_e1_inta", 16'(interrupt_acknowledge_n), 16'd0);
        tick();
        chk("a_e2_inta", 16'(interrupt_acknowledge_n), 16'd1);
        chk("a_e2_valid", 16'(vector_valid), 16'd0);
        data_bus_in = 8'h48;
        tick();
        chk("a_e3_inta", 16'(interrupt_acknowledge_n), 16'd1);
        tick();
        chk("a_e4_inta", 16'(interrupt_acknowledge_n), 16'd0);
        tick();
        chk("a_e5_inta", 16'(interrupt_acknowledge_n), 16'd0);
        tick();
        chk("a_e6_inta", 16'(interrupt_acknowledge_n), 16'd1);
        chk("a_e6_valid", 16'(vector_valid), 16'd1);
        chk("a_e6_data", vector_data, 16'h0048);
        chk("a_e6_err", 16'(opcode_error), 16'd0);
        data_bus_in = 8'h00;
        tick();
        chk("a_hold_valid", 16'(vector_valid), 16'd1);
        vector_ready = 1'b1;
        tick();
        chk("a_hs_valid", 16'(vector_valid), 16'd0);
        chk("a_hs_busy", 16'(busy), 16'd0);
        vector_ready = 1'b0;

        // MCS-80: CD / 20 / 3F; mode change mid-sequence must be ignored
        u8086_or_mcs80_config = 1'b0;
        interrupt_request = 1'b1;
        data_bus_in = 8'hCD;
        tick();  // edge 0
        chk("b_e0_inta", 16'(interrupt_acknowledge_n), 16'd0);
        u8086_or_mcs80_config = 1'b1;
        tick();
        tick();  // edge 2
        chk("b_e2_inta", 16'(interrupt_acknowledge_n), 16'd1);
        chk("b_e2_data", vector_data, 16'h0048);
        data_bus_in = 8'h20;
        tick();
        tick();  // edge 4
        chk("b_e4_inta", 16'(interrupt_acknowledge_n), 16'd0);
        tick();
        tick();  // edge 6
        chk("b_e6_inta", 16'(interrupt_acknowledge_n), 16'd1);
        chk("b_e6_valid", 16'(vector_valid), 16'd0);
        chk("b_e6_data", vector_data, 16'h0048);
        data_bus_in = 8'h3F;
        tick();
        tick();  // edge 8
        chk("b_e8_inta", 16'(interrupt_acknowledge_n), 16'd0);
        tick();
        tick();  // edge 10
        chk("b_e10_inta", 16'(interrupt_acknowledge_n), 16'd1);
        chk("b_e10_valid", 16'(vector_valid), 16'd1);
        chk("b_e10_data", vector_data, 16'h3F20);
        chk("b_e10_err", 16'(opcode_error), 16'd0);
        data_bus_in = 8'h00;

        // hold with request still high and no ready for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_inta", 16'(interrupt_acknowledge_n), 16'd1);
            chk("hold_data", vector_data, 16'h3F20);
            chk("hold_valid", 16'(vector_valid), 16'd1);
        end
        vector_ready = 1'b1;
        tick();  // handshake edge: request present but must not start
        chk("hs_valid", 16'(vector_valid), 16'd0);
        chk("hs_busy", 16'(busy), 16'd0);
        chk("hs_inta", 16'(interrupt_acknowledge_n), 16'd1);
        vector_ready = 1'b0;
        tick();  // first idle edge starts the next sequence (8086 now)
        chk("restart_inta", 16'(interrupt_acknowledge_n), 16'd0);
        chk("restart_busy", 16'(busy), 16'd1);
        interrupt_request = 1'b0;

        // reset in the middle of pulse 2
        tick();
        tick();
        tick();
        tick();  // edge 4: pulse 2 low
        chk("c_p2_inta", 16'(interrupt_acknowledge_n), 16'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("c_rst_inta", 16'(interrupt_acknowledge_n), 16'd1);
        chk("c_rst_valid", 16'(vector_valid), 16'd0);
        chk("c_rst_busy", 16'(busy), 16'd0);
        chk("c_rst_data", vector_data, 16'h0000);

        // release with request high but interrupts disabled
        interrupt_enable = 1'b0;
        interrupt_request = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("dis_inta", 16'(interrupt_acknowledge_n), 16'd1);
            chk("dis_busy", 16'(busy), 16'd0);
        end
        interrupt_enable = 1'b1;
        data_bus_in = 8'h11;
        tick();  // edge 0
        chk("d_e0_inta", 16'(interrupt_acknowledge_n), 16'd0);
        interrupt_request = 1'b0;
        tick();
        tick();
        data_bus_in = 8'h5A;
        tick();
        tick();
        tick();
        tick();  // edge 6
        chk("d_e6_valid", 16'(vector_valid), 16'd1);
        chk("d_e6_data", vector_data, 16'h005A);
        vector_ready = 1'b1;
        tick();
        chk("d_hs_valid", 16'(vector_valid), 16'd0);
        vector_ready = 1'b0;

        // MCS-80 with a wrong opcode byte
        u8086_or_mcs80_config = 1'b0;
        interrupt_request = 1'b1;
        data_bus_in = 8'hC3;
        tick();  // edge 0
        interrupt_request = 1'b0;
        tick();
        tick();  // edge 2
        chk("e_e2_err", 16'(opcode_error), 16'd0);
        data_bus_in = 8'h11;
        tick();
        tick();
        tick();
        tick();  // edge 6
        data_bus_in = 8'h22;
        tick();
        tick();
        tick();
        tick();  // edge 10
        chk("e_e10_valid", 16'(vector_valid), 16'd1);
        chk("e_e10_data", vector_data, 16'h2211);
        chk("e_e10_err", 16'(opcode_error), 16'(EXP_BAD_OPC));
        vector_ready = 1'b1;
        tick();
        chk("e_hs_valid", 16'(vector_valid), 16'd0);
        chk("e_hs_err", 16'(opcode_error), 16'd0);
        vector_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have parameter INTA_LOW_CYCLES, default 2, clocks interrupt_acknowledge_n is held low per pulse (legal 1..15).
REQ-002 SHALL have parameter INTA_GAP_CYCLES, default 2, clocks interrupt_acknowledge_n is held high between pulses (legal 1..15).
REQ-003 SHALL have port clock  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port interrupt_request  in  1  INT from the controller, active high.
REQ-006 SHALL have port interrupt_enable  in  1  CPU interrupt-enable flag; 0 blocks new sequences.
REQ-007 SHALL have port u8086_or_mcs80_config  in  1  1 = 8086 (two pulses), 0 = MCS-80 (three pulses).
REQ-008 SHALL have port data_bus_in  in  8  data bus driven by the controller during acknowledge pulses.
REQ-009 SHALL have port vector_ready  in  1  consumer accepts vector_data.
REQ-010 SHALL have port interrupt_acknowledge_n  out  1  INTA strobe, active low.
REQ-011 SHALL have port busy  out  1  high from sequence start until vector handshake completes.
REQ-012 SHALL have port vector_valid  out  1  vector_data holds a captured result.
REQ-013 SHALL have port vector_data  out  16  8086: {8'h00, type}; MCS-80: {high byte, low byte}.
REQ-014 SHALL have port opcode_error  out  1  MCS-80 first byte is not 8'hCD (only with the Configuration macro).

Function
REQ-015 SHALL implement states IDLE, PULSE_LOW, PULSE_GAP and HOLD, with a 2-bit pulse index and a 4-bit cycle counter.
REQ-016 In IDLE, SHALL start a sequence at edge 0 when interrupt_request=1, interrupt_enable=1 and vector_valid=0, and SHALL drive interrupt_acknowledge_n low after that edge.
REQ-017 SHALL latch u8086_or_mcs80_config at the start of the sequence; later changes have no effect until the next sequence.
REQ-018 PULSE_LOW SHALL last INTA_LOW_CYCLES clocks; the edge that ends it SHALL sample data_bus_in and raise interrupt_acknowledge_n.
REQ-019 PULSE_GAP SHALL last INTA_GAP_CYCLES clocks, then go to PULSE_LOW of the next pulse.
REQ-020 8086 capture: pulse 1 data is discarded; pulse 2 data goes to vector_data[7:0]; vector_data[15:8]=0.
REQ-021 MCS-80 capture: pulse 1 is the opcode; pulse 2 goes to vector_data[7:0]; pulse 3 goes to vector_data[15:8].
REQ-022 The edge that ends the last pulse SHALL set vector_valid=1 and move to HOLD.
REQ-023 In HOLD, vector_data SHALL stay stable; vector_valid&&vector_ready at an edge SHALL clear vector_valid and busy and return to IDLE.
REQ-024 Once started, a sequence SHALL complete even if interrupt_request or interrupt_enable drops.
REQ-025 A request present in the cycle of the handshake SHALL NOT start a sequence until the next edge in IDLE (at least one idle clock between sequences).
REQ-026 vector_data SHALL update only at capture edges; intermediate bytes are visible only after vector_valid.

Reset
REQ-027 On reset_n=0 (asynchronous), the block SHALL set interrupt_acknowledge_n=1, busy=0, vector_valid=0, vector_data=16'h0000, opcode_error=0 and the state to IDLE.
REQ-028 Reset during a pulse SHALL raise interrupt_acknowledge_n immediately and abandon the partial capture.
REQ-029 After reset release, the first sequence SHALL start no earlier than the first rising edge with reset_n=1.

Configuration
REQ-030 With macro INTA_OPCODE_CHECK_EN defined, in MCS-80 mode, a pulse-1 byte other than 8'hCD SHALL set opcode_error with vector_valid; the sequence still completes; opcode_error clears on the handshake.
REQ-031 Without INTA_OPCODE_CHECK_EN, opcode_error SHALL be tied to 0 and pulse-1 data is ignored.

Verification
REQ-032 8086, defaults, request at edge 0, bus=8'h48 on pulse 2 -> INTA_n low after edges 0 and 4, high after edges 2 and 6; vector_valid=1 and vector_data=16'h0048 after edge 6.
REQ-033 MCS-80, bus CD/20/3F on pulses 1/2/3 -> three pulses (low after edges 0, 4, 8); vector_data=16'h3F20 after edge 10; opcode_error=0.
REQ-034 INTA_OPCODE_CHECK_EN, MCS-80, pulse-1 byte 8'hC3 -> opcode_error=1 together with vector_valid; both clear on the vector_ready handshake.
REQ-035 Hold vector_ready=0 for 5 cycles with the request still high -> no new INTA pulses; vector_data stable; new sequence starts only after the handshake plus one IDLE edge.
REQ-036 Drop interrupt_request after pulse 1, and separately assert reset_n=0 during pulse 2 -> first case completes normally; second case gives INTA_n=1 asynchronously, vector_valid=0, IDLE.
REQ-037 interrupt_enable=0 with request high for 10 cycles -> INTA_n stays 1 and busy=0; enabling it starts a sequence at the next edge.
